// File: rtl/immgen_pkg.sv
// Shared definitions for the immediate-generation stage: opcode keys, immediate
// kinds and the decoded bundle carried through the skid buffer.
package immgen_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_Z     = 3'd7
    } imm_type_e;

    // Address-sized fields are held at the widest XLEN; narrower builds zero-extend.
    typedef struct packed {
        logic [31:0]         instr;
        logic [MAX_XLEN-1:0] pc;
        logic [MAX_XLEN-1:0] imm;
        imm_type_e           imm_type;
        logic [MAX_XLEN-1:0] pc_imm;
        logic                illegal;
    } imm_bundle_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: builds the full bundle (imm, kind, pc+imm,
// illegal-shift flag) for one instruction.
module imm_decode
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output imm_bundle_t     bundle
);

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic            illegal;

    // Every form fits in 32 bits with its sign at bit 31; zero-extended forms keep bit 31 clear.
    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (instr[6:2])
            OPC_LUI, OPC_AUIPC: begin
                imm32    = {instr[31:12], 12'b0};
                imm_type = IMM_U;
            end
            OPC_JAL: begin
                imm32    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                imm_type = IMM_J;
            end
            OPC_JALR, OPC_LOAD: begin
                imm32    = {{20{instr[31]}}, instr[31:20]};
                imm_type = IMM_I;
            end
            OPC_BRANCH: begin
                imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                imm_type = IMM_B;
            end
            OPC_STORE: begin
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm_type = IMM_S;
            end
            OPC_OP_IMM: begin
                if (instr[13:12] == 2'b01) begin
                    // instr[25] is part of the amount on RV64 and an encoding error on RV32
                    imm32    = {26'b0, instr[25:20]};
                    imm_type = IMM_SHAMT;
                    illegal  = (XLEN == 32) && instr[25];
                end else begin
                    imm32    = {{20{instr[31]}}, instr[31:20]};
                    imm_type = IMM_I;
                end
            end
            OPC_SYSTEM: begin
                if (instr[14]) begin
                    imm32    = {27'b0, instr[19:15]};
                    imm_type = IMM_Z;
                end
            end
            default: ;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    always_comb begin
        bundle          = '0;
        bundle.instr    = instr;
        bundle.pc       = MAX_XLEN'(pc);
        bundle.imm      = MAX_XLEN'(imm);
        bundle.imm_type = imm_type;
        bundle.pc_imm   = MAX_XLEN'(pc + imm);
        bundle.illegal  = illegal;
    end

endmodule

// File: rtl/immgen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer so upstream
// ready never depends combinationally on downstream ready.
//
//   state | meaning
//   EMPTY | no entry held, OUT and SKID invalid
//   ONE   | OUT holds the oldest entry, SKID free
//   FULL  | OUT and SKID both hold entries, upstream stalled
module immgen_stage
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_imm_type,
    output logic [XLEN-1:0] o_pc_imm,
    output logic            o_illegal
);

    // Encoding is {OUT.valid, SKID.valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    state_e      state_q, state_d;
    imm_bundle_t in_b, out_q, skid_q;
    logic        accept, ld_out_in, ld_out_skid, ld_skid;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr  (i_instr),
        .pc     (i_pc),
        .bundle (in_b)
    );

    assign accept = i_valid && !state_q[0];

    always_comb begin
        state_d     = state_q;
        ld_out_in   = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    ld_out_in = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && i_ready) begin
                    ld_out_in = 1'b1;
                end else if (accept) begin
                    ld_skid = 1'b1;
                    state_d = ST_FULL;
                end else if (i_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (i_ready) begin
                    ld_out_skid = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (i_flush) begin
            state_d     = ST_EMPTY;
            ld_out_in   = 1'b0;
            ld_out_skid = 1'b0;
            ld_skid     = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (ld_out_in) begin
                out_q <= in_b;
            end else if (ld_out_skid) begin
                out_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= in_b;
            end
        end
    end

    assign o_ready    = !state_q[0];
    assign o_valid    = state_q[1];
    assign o_instr    = out_q.instr;
    assign o_pc       = XLEN'(out_q.pc);
    assign o_imm      = XLEN'(out_q.imm);
    assign o_imm_type = out_q.imm_type;
    assign o_pc_imm   = XLEN'(out_q.pc_imm);
    assign o_illegal  = out_q.illegal;

endmodule

// File: tb/tb_immgen_stage.sv
// Directed bench for immgen_stage: one XLEN=32 and one XLEN=64 instance share
// the control inputs; expected values are hand-computed.
module tb_immgen_stage;

    logic        clk, rst_n, flush, valid, ready;
    logic [31:0] instr;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        rdy32, val32, ill32;
    logic [31:0] ins32, opc32, imm32, pci32;
    logic [2:0]  typ32;
    logic        rdy64, val64, ill64;
    logic [31:0] ins64;
    logic [63:0] opc64, imm64, pci64;
    logic [2:0]  typ64;

    int total = 0;
    int bad   = 0;

    immgen_stage #(.XLEN(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy32),
        .i_instr(instr), .i_pc(pc32), .o_valid(val32), .i_ready(ready), .o_instr(ins32),
        .o_pc(opc32), .o_imm(imm32), .o_imm_type(typ32), .o_pc_imm(pci32), .o_illegal(ill32)
    );

    immgen_stage #(.XLEN(64)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy64),
        .i_instr(instr), .i_pc(pc64), .o_valid(val64), .i_ready(ready), .o_instr(ins64),
        .o_pc(opc64), .o_imm(imm64), .o_imm_type(typ64), .o_pc_imm(pci64), .o_illegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single cycle, then sample the result half a cycle later.
    task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
        @(negedge clk);
        valid = 1'b1;
        instr = ins;
        pc32  = pc[31:0];
        pc64  = pc;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b1;
        instr = '0; pc32 = '0; pc64 = '0;
        #2;
        chk("rst_valid", val32, 0);
        chk("rst_ready", rdy32, 1);
        chk("rst_imm",   imm32, 0);
        chk("rst_type",  typ32, 0);
        chk("rst_ill",   ill32, 0);
        chk("rst_pcimm", pci32, 0);
        chk("rst_imm64", imm64, 0);
        #10 rst_n = 1'b1;

        issue(32'hFFF00093, 64'h100);
        chk("addi_valid", val32, 1);
        chk("addi_instr", ins32, 32'hFFF00093);
        chk("addi_pc",    opc32, 32'h100);
        chk("addi_imm",   imm32, 32'hFFFFFFFF);
        chk("addi_type",  typ32, 1);
        chk("addi_pcimm", pci32, 32'h000000FF);
        chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);

        issue(32'hFE000EE3, 64'h200);
        chk("beq_imm",   imm32, 32'hFFFFFFFC);
        chk("beq_type",  typ32, 3);
        chk("beq_pcimm", pci32, 32'h000001FC);
        chk("beq_pcimm64", pci64, 64'h1FC);

        issue(32'h02009093, 64'h300);
        chk("slli_imm",   imm32, 32'h20);
        chk("slli_type",  typ32, 6);
        chk("slli_ill32", ill32, 1);
        chk("slli_imm64", imm64, 64'h20);
        chk("slli_ill64", ill64, 0);
        chk("slli_pcimm", pci32, 32'h320);

        issue(32'h300FD073, 64'h400);
        chk("csr_imm",  imm32, 32'h1F);
        chk("csr_type", typ32, 7);
        chk("csr_ill",  ill32, 0);

        issue(32'h800000B7, 64'h10);
        chk("lui_imm64",   imm64, 64'hFFFFFFFF80000000);
        chk("lui_type64",  typ64, 4);
        chk("lui_pcimm64", pci64, 64'hFFFFFFFF80000010);
        chk("lui_imm32",   imm32, 32'h80000000);

        issue(32'hFE112E23, 64'h20);
        chk("sw_imm",   imm32, 32'hFFFFFFFC);
        chk("sw_type",  typ32, 2);
        chk("sw_pcimm", pci32, 32'h1C);

        issue(32'h008000EF, 64'h100);
        chk("jal_imm",   imm32, 32'h8);
        chk("jal_type",  typ32, 5);
        chk("jal_pcimm", pci64, 64'h108);

        issue(32'h00000033, 64'h40);
        chk("op_imm",  imm32, 0);
        chk("op_type", typ32, 0);
        chk("op_ill",  ill32, 0);

        // Backpressure: A, B, C with downstream stalled
        @(negedge clk);
        chk("bp_idle", val32, 0);
        ready = 1'b0; valid = 1'b1; instr = 32'hFFF00093; pc32 = 32'h100; pc64 = 64'h100;
        @(negedge clk);
        chk("bp_a_ready", rdy32, 1);
        instr = 32'hFE000EE3; pc32 = 32'h200; pc64 = 64'h200;
        @(negedge clk);
        chk("bp_full_ready", rdy32, 0);
        chk("bp_a_out",      ins32, 32'hFFF00093);
        instr = 32'h02009093; pc32 = 32'h300; pc64 = 64'h300;
        @(negedge clk);
        chk("bp_hold_ready", rdy64, 0);
        chk("bp_hold_instr", ins32, 32'hFFF00093);
        chk("bp_hold_imm",   imm32, 32'hFFFFFFFF);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_b_valid", val32, 1);
        chk("bp_b_instr", ins32, 32'hFE000EE3);
        chk("bp_b_imm",   imm32, 32'hFFFFFFFC);
        chk("bp_b_ready", rdy32, 1);
        @(negedge clk);
        valid = 1'b0;
        chk("bp_c_valid", val32, 1);
        chk("bp_c_instr", ins32, 32'h02009093);
        chk("bp_c_ill",   ill32, 1);
        @(negedge clk);
        chk("bp_drained", val32, 0);

        // Flush from FULL with a new instruction offered in the same cycle
        ready = 1'b0; valid = 1'b1; instr = 32'h00000013;
        @(negedge clk);
        instr = 32'h00100093;
        @(negedge clk);
        chk("fl_full_ready", rdy32, 0);
        flush = 1'b1; instr = 32'h00200113;
        @(negedge clk);
        flush = 1'b0; valid = 1'b0;
        chk("fl_valid",   val32, 0);
        chk("fl_ready",   rdy32, 1);
        chk("fl_valid64", val64, 0);
        ready = 1'b1;
        @(negedge clk);
        chk("fl_stay_empty", val32, 0);

        // Asynchronous reset in mid-cycle
        ready = 1'b0;
        issue(32'hFFF00093, 64'h100);
        chk("ar_pre_valid", val32, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", val32, 0);
        chk("ar_ready", rdy32, 1);
        chk("ar_imm",   imm32, 0);
        chk("ar_type",  typ64, 0);
        #1 rst_n = 1'b1;
        ready = 1'b1;
        issue(32'h300FD073, 64'h400);
        chk("ar_first_valid", val32, 1);
        chk("ar_first_imm",   imm32, 32'h1F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
